// File: rtl/spi_slave_drive_if.sv
// SPI pin bundle plus user-side payload handshake for spi_slave_drive.
// The slave modport is the responder; master is the pad/user side.
interface spi_slave_drive_if #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 24
);
    logic                    i_spi_clk;
    logic                    i_spi_cs;
    logic                    i_spi_mosi;
    logic                    o_spi_miso;
    logic                    o_spi_miso_en;
    logic [7:0]              o_opcode;
    logic                    o_opcode_valid;
    logic [P_ADDR_WIDTH-1:0] o_addr;
    logic                    o_addr_valid;
    logic [P_DATA_WIDTH-1:0] o_write_data;
    logic                    o_write_valid;
    logic                    o_read_req;
    logic [P_DATA_WIDTH-1:0] i_read_data;
    logic                    o_frame_done;

    modport slave (
        input  i_spi_clk, i_spi_cs, i_spi_mosi, i_read_data,
        output o_spi_miso, o_spi_miso_en,
        output o_opcode, o_opcode_valid,
        output o_addr, o_addr_valid,
        output o_write_data, o_write_valid,
        output o_read_req, o_frame_done
    );

    modport master (
        output i_spi_clk, i_spi_cs, i_spi_mosi, i_read_data,
        input  o_spi_miso, o_spi_miso_en,
        input  o_opcode, o_opcode_valid,
        input  o_addr, o_addr_valid,
        input  o_write_data, o_write_valid,
        input  o_read_req, o_frame_done
    );
endinterface

// File: rtl/spi_slave_drive.sv
// Oversampling SPI responder (CPHA=0): opcode + address header decode,
// write payload to the user, read payload from the user onto MISO.
module spi_slave_drive #(
    parameter int         P_DATA_WIDTH   = 8,
    parameter int         P_ADDR_WIDTH   = 24,
    parameter bit         P_CPOL         = 1'b0,
    parameter logic [7:0] P_READ_OPCODE  = 8'h03,
    parameter logic [7:0] P_WRITE_OPCODE = 8'h02,
    parameter logic [7:0] P_ERASE_OPCODE = 8'h20
) (
    input logic               i_clk,
    input logic               i_rst,
    spi_slave_drive_if.slave  bus
);
    localparam int AW = P_ADDR_WIDTH;
    localparam int DW = P_DATA_WIDTH;
    localparam int AC = $clog2(AW);
    localparam int DC = $clog2(DW);

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ADDR, S_WRITE,
        S_READ, S_IGNORE, S_WAIT_CS
    } state_t;

    state_t state, state_d;

    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    logic sclk_rise, sclk_fall, lead, trail;
    logic cs_rise, cs_fall, cs_hi, mosi_s;
    logic lead_v, trail_v;

    logic [2:0]    op_cnt;
    logic [AC-1:0] addr_cnt;
    logic [DC-1:0] data_cnt;
    logic [6:0]    op_sh;
    logic [AW-2:0] addr_sh;
    logic [DW-2:0] wr_sh, rd_sh;
    logic [7:0]    op_next;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] wr_next, rd_buf;
    logic op_last, addr_last, data_last, op_known;
    logic rd_full, rd_pend;

    logic [7:0]    opcode_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic opcode_v, addr_v, wvalid, rreq, done_q, miso_q;

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_q <= {3{P_CPOL}};
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.i_spi_clk};
            cs_q   <= {cs_q[1:0], bus.i_spi_cs};
            mosi_q <= {mosi_q[0], bus.i_spi_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign lead      = P_CPOL ? sclk_fall : sclk_rise;
    assign trail     = P_CPOL ? sclk_rise : sclk_fall;
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_hi     = cs_q[1];
    assign mosi_s    = mosi_q[1];
    // CS deassertion outranks a coincident clock edge.
    assign lead_v    = lead & ~cs_rise;
    assign trail_v   = trail & ~cs_rise;

    assign op_next   = {op_sh, mosi_s};
    assign addr_next = {addr_sh, mosi_s};
    assign wr_next   = {wr_sh, mosi_s};
    assign op_last   = (op_cnt == 3'd7);
    assign addr_last = (addr_cnt == AC'(AW - 1));
    assign data_last = (data_cnt == DC'(DW - 1));
    assign op_known  = (op_next == P_READ_OPCODE)
                    || (op_next == P_WRITE_OPCODE)
                    || (op_next == P_ERASE_OPCODE);

    // State register; reset parks in WAIT_CS to skip a frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_WAIT_CS;
        else       state <= state_d;
    end

    // Next-state decode for the frame phases.
    always_comb begin
        state_d = state;
        unique case (state)
            S_WAIT_CS: if (cs_hi) state_d = S_IDLE;
            S_IDLE:    if (cs_fall) state_d = S_OPCODE;
            S_OPCODE:
                if (lead_v && op_last)
                    state_d = op_known ? S_ADDR : S_IGNORE;
            S_ADDR:
                if (lead_v && addr_last) begin
                    if (opcode_q == P_READ_OPCODE)
                        state_d = S_READ;
                    else if (opcode_q == P_WRITE_OPCODE)
                        state_d = S_WRITE;
                    else
                        state_d = S_IGNORE;
                end
            S_WRITE, S_READ, S_IGNORE: ;
            default: state_d = S_WAIT_CS;
        endcase
        if (cs_rise && state != S_WAIT_CS)
            state_d = S_IDLE;
    end

    // Field shifters, counters, user strobes and the MISO path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_cnt   <= '0;
            addr_cnt <= '0;
            data_cnt <= '0;
            op_sh    <= '0;
            addr_sh  <= '0;
            wr_sh    <= '0;
            rd_sh    <= '0;
            rd_buf   <= '0;
            rd_full  <= 1'b0;
            rd_pend  <= 1'b0;
            opcode_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            opcode_v <= 1'b0;
            addr_v   <= 1'b0;
            wvalid   <= 1'b0;
            rreq     <= 1'b0;
            done_q   <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            opcode_v <= 1'b0;
            addr_v   <= 1'b0;
            wvalid   <= 1'b0;
            rreq     <= 1'b0;
            done_q   <= cs_rise && (state != S_WAIT_CS);
            rd_pend  <= rreq;

            if (state == S_IDLE && cs_fall) begin
                op_cnt   <= '0;
                addr_cnt <= '0;
                data_cnt <= '0;
                rd_sh    <= '0;
                rd_full  <= 1'b0;
            end

            if (state == S_OPCODE && lead_v) begin
                op_sh  <= op_next[6:0];
                op_cnt <= op_cnt + 3'd1;
                if (op_last) begin
                    opcode_q <= op_next;
                    opcode_v <= 1'b1;
                end
            end

            if (state == S_ADDR && lead_v) begin
                addr_sh <= addr_next[AW-2:0];
                if (addr_last) begin
                    addr_cnt <= '0;
                    addr_q   <= addr_next;
                    addr_v   <= 1'b1;
                    rreq     <= (opcode_q == P_READ_OPCODE);
                end else begin
                    addr_cnt <= addr_cnt + AC'(1);
                end
            end

            if (state == S_WRITE && lead_v) begin
                wr_sh <= wr_next[DW-2:0];
                if (data_last) begin
                    data_cnt <= '0;
                    wdata_q  <= wr_next;
                    wvalid   <= 1'b1;
                end else begin
                    data_cnt <= data_cnt + DC'(1);
                end
            end

            if (state == S_READ && lead_v) begin
                if (data_last) begin
                    data_cnt <= '0;
                    rreq     <= 1'b1;
                end else begin
                    data_cnt <= data_cnt + DC'(1);
                end
            end

            if (state == S_READ && trail_v) begin
                if (rd_full) begin
                    rd_full <= 1'b0;
                    miso_q  <= rd_buf[DW-1];
                    rd_sh   <= rd_buf[DW-2:0];
                end else begin
                    miso_q  <= rd_sh[DW-2];
                    rd_sh   <= {rd_sh[DW-3:0], 1'b0};
                end
            end

            if (rd_pend) begin
                rd_buf  <= bus.i_read_data;
                rd_full <= 1'b1;
            end

            if (state_d != S_READ)
                miso_q <= 1'b0;
        end
    end

    assign bus.o_spi_miso     = miso_q;
    assign bus.o_spi_miso_en  = (state == S_READ);
    assign bus.o_opcode       = opcode_q;
    assign bus.o_opcode_valid = opcode_v;
    assign bus.o_addr         = addr_q;
    assign bus.o_addr_valid   = addr_v;
    assign bus.o_write_data   = wdata_q;
    assign bus.o_write_valid  = wvalid;
    assign bus.o_read_req     = rreq;
    assign bus.o_frame_done   = done_q;
endmodule
